// File: rtl/ring_osc_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of osc_in over GATE_CYCLES clk cycles.
// Optional macro RO_FREQ_METER_CONT_EN: re-arm after every window (continuous mode).
module ring_osc_freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow
);
  localparam int TW = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0]    TLOAD = TW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMAX  = '1;

  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

  state_t           state, state_nx;
  logic [2:0]       sync_pipe;
  logic             rise;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ovf, ovf_nx;

  // sync_pipe[0]=s1, [1]=s2, [2]=s3 (previous s2)
  always_ff @(posedge clk) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[1:0], osc_in};
  end

  assign rise = sync_pipe[1] & ~sync_pipe[2];

  // Accumulator value including this cycle's edge, so the last gate cycle still counts.
  always_comb begin
    cnt_nx = cnt;
    ovf_nx = ovf;
    if (rise) begin
      if (cnt == CMAX) ovf_nx = 1'b1;
      else             cnt_nx = cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = ARM;
      ARM:  state_nx = GATE;
      GATE: if (timer == '0) state_nx = DONE;
`ifdef RO_FREQ_METER_CONT_EN
      DONE: state_nx = ARM;
`else
      DONE: state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // count/overflow/count_valid load on entry to DONE so they are valid during DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      count       <= '0;
      overflow    <= 1'b0;
      count_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      count_valid <= 1'b0;
      case (state)
        ARM: begin
          cnt   <= '0;
          ovf   <= 1'b0;
          timer <= TLOAD;
        end
        GATE: begin
          cnt <= cnt_nx;
          ovf <= ovf_nx;
          if (timer == '0) begin
            count       <= cnt_nx;
            overflow    <= ovf_nx;
            count_valid <= 1'b1;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Directed bench for ring_osc_freq_meter: a 16-bit and a 4-bit instance, both with a 100-cycle gate.
module tb_ring_osc_freq_meter;
  logic        clk = 1'b0;
  logic        rst, osc, start_a, start_b;
  logic        busy_a, cv_a, ov_a, busy_b, cv_b, ov_b;
  logic [15:0] count_a;
  logic [3:0]  count_b;
  int          mode = 0;
  int          ncmp = 0, nerr = 0;
  int          lat, pulses, bad;

  ring_osc_freq_meter #(.GATE_CYCLES(100), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start_a),
    .busy(busy_a), .count(count_a), .count_valid(cv_a), .overflow(ov_a));

  ring_osc_freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start_b),
    .busy(busy_b), .count(count_b), .count_valid(cv_b), .overflow(ov_b));

  always #5 clk = ~clk;

  // osc source: 0 = static low, 1 = period 10 clk (5 high / 5 low), 2 = toggle every clk
  initial begin : oscgen
    int ph;
    ph  = 0;
    osc = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (mode)
        1:       begin ph = (ph + 1) % 10; osc = (ph < 5); end
        2:       osc = ~osc;
        default: osc = 1'b0;
      endcase
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; lat = cycles from the start cycle to the cycle count_valid is seen.
  task automatic run(input bit a, input bit b, output int l);
    @(posedge clk); #1;
    start_a = a; start_b = b;
    @(negedge clk);
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    l = 0;
    while (l < 400) begin
      @(negedge clk);
      l++;
      if (a ? cv_a : cv_b) break;
    end
  endtask

  task automatic settle(input int m);
    mode = m;
    repeat (6) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_count", count_a, 0);
    chk("rst_cv", cv_a, 0);
    chk("rst_ovf", ov_a, 0);

`ifdef RO_FREQ_METER_CONT_EN
    settle(1);
    run(1, 0, lat);
    chk("cont_lat0", lat, 102);
    chk("cont_cnt0", count_a, 10);
    for (int w = 1; w <= 3; w++) begin
      lat = 0; bad = 0;
      while (lat < 400) begin
        @(negedge clk);
        lat++;
        if (!busy_a) bad++;
        if (cv_a) break;
      end
      chk("cont_period", lat, 102);
      chk("cont_cnt", count_a, 10);
      chk("cont_busy_low", bad, 0);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("cont_rst_busy", busy_a, 0);
    chk("cont_rst_count", count_a, 0);
`else
    // static input: latency and zero count
    settle(0);
    run(1, 0, lat);
    chk("static_lat", lat, 102);
    chk("static_cnt", count_a, 0);
    chk("static_ovf", ov_a, 0);
    @(negedge clk);
    chk("cv_one_cycle", cv_a, 0);
    chk("idle_after_done", busy_a, 0);

    // period-10 input
    settle(1);
    run(1, 0, lat);
    chk("p10_lat", lat, 102);
    chk("p10_cnt", count_a, 10);
    chk("p10_ovf", ov_a, 0);
    repeat (10) @(negedge clk);
    chk("p10_hold", count_a, 10);

    // toggle every clk: 50 rises; 4-bit instance saturates
    settle(2);
    run(1, 1, lat);
    chk("tog_lat", lat, 102);
    chk("tog_cnt16", count_a, 50);
    chk("tog_ovf16", ov_a, 0);
    chk("tog_cv4", cv_b, 1);
    chk("tog_cnt4", count_b, 15);
    chk("tog_ovf4", ov_b, 1);

    // overflow is cleared by the next window
    settle(0);
    run(0, 1, lat);
    chk("clr_lat", lat, 102);
    chk("clr_cnt4", count_b, 0);
    chk("clr_ovf4", ov_b, 0);

    // start during GATE is ignored and not queued
    settle(1);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (50) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    pulses = 0;
    repeat (200) begin
      @(negedge clk);
      if (cv_a) pulses++;
    end
    chk("restart_pulses", pulses, 1);
    chk("restart_busy", busy_a, 0);
    chk("restart_cnt", count_a, 10);

    // reset mid-window discards the partial count
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_cnt", count_a, 0);
    chk("midrst_cv", cv_a, 0);
    chk("midrst_ovf", ov_a, 0);
    pulses = 0;
    repeat (110) begin
      @(negedge clk);
      if (cv_a) pulses++;
    end
    chk("midrst_no_cv", pulses, 0);
    run(1, 0, lat);
    chk("after_rst_lat", lat, 102);
    chk("after_rst_cnt", count_a, 10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
